// File: rtl/led_fade_pwm_driver.sv
// Soft-fading PWM LED driver: each channel ramps its brightness toward on/off targets from the LED PIO.
// Optional `LED_FADE_GAMMA_EN squares the level into the PWM duty for perceptually even fades.
module led_fade_pwm_driver #(
   parameter int NUM_LEDS = 8,
   parameter int PWM_BITS = 8,
   parameter int STEP_DIV = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_LEDS-1:0] in_port,
   output logic [NUM_LEDS-1:0] led_out,
   output logic                busy
);

   localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_DIV - 1);

   localparam logic [1:0] ST_OFF  = 2'd0;
   localparam logic [1:0] ST_RISE = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;
   localparam logic [1:0] ST_FALL = 2'd3;

   logic [NUM_LEDS-1:0] tgt_q;
   logic [TICK_W-1:0]   tick_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                step_tick;

   logic [PWM_BITS-1:0] level_q [NUM_LEDS];
   logic [PWM_BITS-1:0] level_d [NUM_LEDS];
   logic [1:0]          state_q [NUM_LEDS];
   logic [1:0]          state_d [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_d;
   logic                busy_d;

   function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] lvl);
      return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + 1'b1;
   endfunction

   function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] lvl);
      return (lvl == '0) ? '0 : lvl - 1'b1;
   endfunction

   function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_FADE_GAMMA_EN
      logic [2*PWM_BITS-1:0] sq;
      sq = lvl * lvl;
      // Full level must stay constant-on even though MAX*MAX >> PWM_BITS falls just short of it.
      return (lvl == LEVEL_MAX) ? LEVEL_MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
      return lvl;
`endif
   endfunction

   assign step_tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      level_d = level_q;
      state_d = state_q;
      led_d   = '0;
      busy_d  = 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         case (state_q[i])
            ST_OFF:  if (tgt_q[i])  state_d[i] = ST_RISE;
            ST_RISE: if (!tgt_q[i]) state_d[i] = ST_FALL;
            ST_ON:   if (!tgt_q[i]) state_d[i] = ST_FALL;
            ST_FALL: if (tgt_q[i])  state_d[i] = ST_RISE;
            default: state_d[i] = ST_OFF;
         endcase
         // Direction is taken from the already-updated state, so a same-cycle reversal steps the new way.
         if (step_tick) begin
            if (state_d[i] == ST_RISE)      level_d[i] = sat_inc(level_q[i]);
            else if (state_d[i] == ST_FALL) level_d[i] = sat_dec(level_q[i]);
         end
         if (state_d[i] == ST_RISE && level_d[i] == LEVEL_MAX)
            state_d[i] = ST_ON;
         else if (state_d[i] == ST_FALL && level_d[i] == '0)
            state_d[i] = ST_OFF;

         led_d[i] = (duty_of(level_q[i]) == LEVEL_MAX) || (duty_of(level_q[i]) > pwm_cnt_q);
         busy_d   = busy_d || (state_q[i] == ST_RISE) || (state_q[i] == ST_FALL)
                    || (tgt_q[i] != (level_q[i] != '0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_q      <= '0;
         tick_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         led_out    <= '0;
         busy       <= 1'b0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            level_q[i] <= '0;
            state_q[i] <= ST_OFF;
         end
      end else begin
         tgt_q      <= in_port;
         tick_cnt_q <= step_tick ? '0 : tick_cnt_q + 1'b1;
         pwm_cnt_q  <= pwm_cnt_q + 1'b1;
         led_out    <= led_d;
         busy       <= busy_d;
         for (int i = 0; i < NUM_LEDS; i++) begin
            level_q[i] <= level_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

endmodule
